audio_track_recorder: RTL and testbench
=======================================

# audio_track_recorder

Multi-track SRAM record/playback/bounce controller for the codec path. It sits between the audio converter's parallel sample ports and the external 16-bit SRAM, all in the CLOCK_50 domain. It records a mono sample stream into one of NUM_TRACKS fixed-size SRAM regions and loops playback of any recorded track. It also performs an offline "bounce" that mixes two tracks into a third at full clock rate.

## Interface
Parameters:
- SAMPLE_W, 16: sample and SRAM data width, two's complement.
- ADDR_W, 18: SRAM word address width.
- NUM_TRACKS, 4: number of track regions; track t occupies words [t*TRACK_DEPTH, (t+1)*TRACK_DEPTH-1].
- TRACK_DEPTH, 64000: words per track; NUM_TRACKS*TRACK_DEPTH ≤ 2^ADDR_W.

Ports:
- CLOCK_50, in, 1: sole clock, all logic on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- sample_strobe, in, 1: one-cycle pulse per LR frame, already synchronised to CLOCK_50.
- start, in, 1: one-cycle command pulse; acted on only in IDLE.
- stop, in, 1: one-cycle pulse; ends RECORD or PLAY.
- mode, in, 2: sampled with start; 0 = RECORD, 1 = PLAY, 2 = MIX, 3 = reserved (start ignored).
- trk_a, in, clog2(NUM_TRACKS): RECORD/PLAY target; MIX source A.
- trk_b, in, clog2(NUM_TRACKS): MIX source B.
- trk_dst, in, clog2(NUM_TRACKS): MIX destination.
- audio_in, in, SAMPLE_W: sample captured on sample_strobe.
- audio_out, out, SAMPLE_W: playback sample, held between updates.
- audio_valid, out, 1: one-cycle pulse when audio_out updates.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse on every return to IDLE.
- full, out, 1: RECORD stopped because the track filled; cleared by the next start.
- sram_addr, out, ADDR_W: registered word address.
- sram_wdata, out, SAMPLE_W: registered write data.
- sram_rdata, in, SAMPLE_W: SRAM read data.
- sram_we_n, out, 1: registered write enable, active low.
- sram_oe_n, out, 1: registered output enable, active low.

## Operation
- Internal state: per-track length registers len[t], width clog2(TRACK_DEPTH+1), all reset to 0; pointer ptr; latched track indices.
- States:
  - IDLE
  - REC_WAIT
  - REC_WR
  - PLAY_WAIT
  - PLAY_RD
  - PLAY_CAP
  - MIX_RD_A
  - MIX_RD_B
  - MIX_CAP
  - MIX_WR
- IDLE + start:
  - Latches mode and track indices; ptr ← 0; full ← 0.
  - RECORD sets len[trk_a] ← 0 and goes to REC_WAIT.
  - PLAY with len[trk_a] = 0 returns to IDLE immediately with a done pulse.
  - MIX computes n = min(len[trk_a], len[trk_b]); n = 0 finishes immediately with len[trk_dst] ← 0.
- RECORD:
  - REC_WAIT + sample_strobe → REC_WR: addr = base(trk_a)+ptr, wdata = audio_in, we_n = 0 for exactly one cycle.
  - Then ptr++ and len++.
  - If ptr reaches TRACK_DEPTH: full ← 1 and go to IDLE.
  - Otherwise return to REC_WAIT.
- PLAY:
  - PLAY_WAIT + sample_strobe → PLAY_RD: oe_n = 0, addr = base+ptr.
  - PLAY_CAP: audio_out ← sram_rdata, audio_valid pulses.
  - ptr wraps to 0 when ptr+1 = len[trk_a], giving looped playback.
- MIX: not strobe-paced; ignores sample_strobe and stop. For each i in 0..n-1:
  - MIX_RD_A reads A[i].
  - MIX_RD_B captures A and reads B[i].
  - MIX_CAP captures B.
  - MIX_WR writes the result to base(trk_dst)+i.
  - After i = n-1: len[trk_dst] ← n, go to IDLE.
- Mix arithmetic: sign-extend both operands to SAMPLE_W+1 and sum; the result is selected by the configuration macro.
- stop:
  - In any REC/PLAY state, stop finishes the in-flight SRAM write or read, then goes to IDLE.
  - A recording keeps every sample written so far.
  - In REC_WAIT or PLAY_WAIT, stop goes to IDLE next cycle.
- Simultaneous events:
  - sample_strobe while in REC_WR, PLAY_RD or PLAY_CAP is dropped.
  - A stop in the same cycle as sample_strobe takes priority: no new access starts.
- trk_dst equal to trk_a or trk_b is legal: the element-wise read-before-write order makes an in-place mix correct.
- Reset values:
  - sram_we_n = 1, sram_oe_n = 1.
  - sram_addr = 0, sram_wdata = 0.
  - audio_out = 0.
  - audio_valid, busy, done, full = 0.
  - All len = 0; state IDLE.
- Reset mid-operation aborts immediately: the next cycle drives we_n = 1, and all SRAM contents are untouched beyond writes already issued.

## Timing
- Strobe at cycle N:
  - RECORD: write strobe (we_n low) at N+1.
  - PLAY: read address at N+1; audio_out and audio_valid at N+3.
- SRAM read data is valid one cycle after the registered address, at 50 MHz asynchronous SRAM speed.
- MIX throughput: 4 cycles per sample.
  - Total duration: 4n + 1 cycles from start to the done pulse.
- we_n and oe_n are never both low; at least one idle cycle separates a write from a read.

## Configuration
- AUDIO_REC_MIX_SATURATE_EN defined: mix result = (A+B) clamped to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
- Not defined: mix result = (A+B) >>> 1 (arithmetic, rounds toward −∞); it can never overflow.

## Test plan
- Record 5 strobes of 0x0001..0x0005 on track 1, then stop → writes to addresses 64000..64004; len[1] = 5; done pulses once; full = 0.
- Play track 1 for 7 strobes → audio_out sequence 1,2,3,4,5,1,2, each appearing 3 cycles after its strobe.
- MIX with A = 0x7000 and B = 0x7000 → dst word 0x7000 without the macro, 0x7FFF with it; with A = 0x8000 and B = 0xFFFF the results are 0xBFFF and 0x8000 respectively.
- Record until the track fills with TRACK_DEPTH reduced to 8 → exactly 8 writes; full = 1; busy drops; the 9th strobe causes no write.
- Assert rst in the middle of MIX_WR → sram_we_n = 1 the next cycle; all outputs at reset values; len[trk_dst] = 0.
- Pulse stop together with sample_strobe in PLAY_WAIT → no read is issued, and done pulses one cycle later.

Source files
------------

// File: rtl/audio_track_recorder_if.sv
// SRAM bus between the recorder (master) and the external 16-bit asynchronous SRAM (slave).
// Every master-driven signal is registered inside the recorder; read data is expected to be
// valid one cycle after the address is presented.
interface audio_track_recorder_if #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned ADDR_W   = 18
);
    logic [ADDR_W-1:0]   sram_addr;
    logic [SAMPLE_W-1:0] sram_wdata;
    logic [SAMPLE_W-1:0] sram_rdata;
    logic                sram_we_n;
    logic                sram_oe_n;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_we_n,
        output sram_oe_n,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_rdata
    );
endinterface

// File: rtl/audio_track_recorder.sv
// Multi-track SRAM record / looped playback / bounce (mix) controller, CLOCK_50 domain.
// Track t occupies SRAM words [t*TRACK_DEPTH, (t+1)*TRACK_DEPTH-1].
// Optional feature macro: AUDIO_REC_MIX_SATURATE_EN
//   defined   : mix result is A+B clamped to the signed sample range
//   undefined : mix result is (A+B) >>> 1, which cannot overflow
module audio_track_recorder #(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned NUM_TRACKS  = 4,
    parameter int unsigned TRACK_DEPTH = 64000,
    localparam int unsigned TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1,
    localparam int unsigned LEN_W      = $clog2(TRACK_DEPTH + 1)
) (
    input  logic                 CLOCK_50,
    input  logic                 rst,
    input  logic                 sample_strobe,
    input  logic                 start,
    input  logic                 stop,
    input  logic [1:0]           mode,
    input  logic [TRK_W-1:0]     trk_a,
    input  logic [TRK_W-1:0]     trk_b,
    input  logic [TRK_W-1:0]     trk_dst,
    input  logic [SAMPLE_W-1:0]  audio_in,
    output logic [SAMPLE_W-1:0]  audio_out,
    output logic                 audio_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 full,
    audio_track_recorder_if.master bus
);

    localparam logic [1:0]       ModeRecord = 2'd0;
    localparam logic [1:0]       ModePlay   = 2'd1;
    localparam logic [1:0]       ModeMix    = 2'd2;
    localparam logic [1:0]       ModeRsvd   = 2'd3;
    localparam logic [LEN_W-1:0] DepthLen   = LEN_W'(TRACK_DEPTH);

    typedef enum logic [3:0] {
        StIdle,
        StRecWait,
        StRecWr,
        StPlayWait,
        StPlayRd,
        StPlayCap,
        StMixRdA,
        StMixRdB,
        StMixCap,
        StMixWr
    } state_e;

    state_e              state_q;
    logic [TRK_W-1:0]    trk_a_q;
    logic [TRK_W-1:0]    trk_b_q;
    logic [TRK_W-1:0]    trk_dst_q;
    logic [LEN_W-1:0]    ptr_q;
    logic [LEN_W-1:0]    mix_n_q;
    logic [LEN_W-1:0]    len_q [NUM_TRACKS];
    logic [SAMPLE_W-1:0] mix_a_q;
    logic                stop_pend_q;

    logic [LEN_W-1:0]    ptr_inc;
    logic [LEN_W-1:0]    len_a;
    logic [LEN_W-1:0]    len_b;
    logic [LEN_W-1:0]    mix_min;
    logic [LEN_W-1:0]    play_len;
    logic [SAMPLE_W:0]   mix_sum;
    logic [SAMPLE_W-1:0] mix_res;

    // First word of a track region.
    function automatic logic [ADDR_W-1:0] base(input logic [TRK_W-1:0] t);
        return ADDR_W'(t) * ADDR_W'(TRACK_DEPTH);
    endfunction

    // Pointer increment and length lookups used by the FSM.
    always_comb begin
        ptr_inc  = ptr_q + LEN_W'(1);
        len_a    = len_q[trk_a];
        len_b    = len_q[trk_b];
        mix_min  = (len_a < len_b) ? len_a : len_b;
        play_len = len_q[trk_a_q];
    end

    // Mix of the captured A sample with B, which is on the read bus during StMixCap.
    always_comb begin
        mix_sum = {mix_a_q[SAMPLE_W-1], mix_a_q}
                + {bus.sram_rdata[SAMPLE_W-1], bus.sram_rdata};
`ifdef AUDIO_REC_MIX_SATURATE_EN
        // Top two sum bits disagree only when A+B left the sample range.
        if (mix_sum[SAMPLE_W] != mix_sum[SAMPLE_W-1]) begin
            mix_res = mix_sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                                        : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            mix_res = mix_sum[SAMPLE_W-1:0];
        end
`else
        mix_res = mix_sum[SAMPLE_W:1];
`endif
    end

    // Control FSM with registered SRAM strobes, status and playback outputs.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q        <= StIdle;
            trk_a_q        <= '0;
            trk_b_q        <= '0;
            trk_dst_q      <= '0;
            ptr_q          <= '0;
            mix_n_q        <= '0;
            mix_a_q        <= '0;
            stop_pend_q    <= 1'b0;
            for (int unsigned t = 0; t < NUM_TRACKS; t++) begin
                len_q[t] <= '0;
            end
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.sram_we_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            audio_out      <= '0;
            audio_valid    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            full           <= 1'b0;
        end else begin
            audio_valid <= 1'b0;
            done        <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start && (mode != ModeRsvd)) begin
                        trk_a_q     <= trk_a;
                        trk_b_q     <= trk_b;
                        trk_dst_q   <= trk_dst;
                        ptr_q       <= '0;
                        full        <= 1'b0;
                        stop_pend_q <= 1'b0;
                        case (mode)
                            ModeRecord: begin
                                len_q[trk_a] <= '0;
                                state_q      <= StRecWait;
                                busy         <= 1'b1;
                            end
                            ModePlay: begin
                                if (len_a == '0) begin
                                    done <= 1'b1;
                                end else begin
                                    state_q <= StPlayWait;
                                    busy    <= 1'b1;
                                end
                            end
                            ModeMix: begin
                                if (mix_min == '0) begin
                                    len_q[trk_dst] <= '0;
                                    done           <= 1'b1;
                                end else begin
                                    mix_n_q       <= mix_min;
                                    bus.sram_addr <= base(trk_a);
                                    state_q       <= StMixRdA;
                                    busy          <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                StRecWait: begin
                    // stop wins over a coincident strobe: no write is started.
                    if (stop) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (sample_strobe) begin
                        bus.sram_addr  <= base(trk_a_q) + ADDR_W'(ptr_q);
                        bus.sram_wdata <= audio_in;
                        bus.sram_we_n  <= 1'b0;
                        state_q        <= StRecWr;
                    end
                end

                StRecWr: begin
                    // The write strobe has been low for this cycle; the sample is committed.
                    bus.sram_we_n   <= 1'b1;
                    ptr_q           <= ptr_inc;
                    len_q[trk_a_q]  <= ptr_inc;
                    if (ptr_inc == DepthLen) begin
                        full    <= 1'b1;
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (stop) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        state_q <= StRecWait;
                    end
                end

                StPlayWait: begin
                    if (stop) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (sample_strobe) begin
                        bus.sram_addr <= base(trk_a_q) + ADDR_W'(ptr_q);
                        bus.sram_oe_n <= 1'b0;
                        state_q       <= StPlayRd;
                    end
                end

                StPlayRd: begin
                    // A stop here is remembered so the read still completes.
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q <= StPlayCap;
                end

                StPlayCap: begin
                    audio_out     <= bus.sram_rdata;
                    audio_valid   <= 1'b1;
                    bus.sram_oe_n <= 1'b1;
                    ptr_q         <= (ptr_inc == play_len) ? '0 : ptr_inc;
                    if (stop || stop_pend_q) begin
                        stop_pend_q <= 1'b0;
                        state_q     <= StIdle;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        state_q <= StPlayWait;
                    end
                end

                StMixRdA: begin
                    // A's address went out with oe_n high: this cycle is the bus turnaround
                    // after the previous element's write. Its data arrives during StMixRdB.
                    bus.sram_addr <= base(trk_b_q) + ADDR_W'(ptr_q);
                    bus.sram_oe_n <= 1'b0;
                    state_q       <= StMixRdB;
                end

                StMixRdB: begin
                    mix_a_q <= bus.sram_rdata;
                    state_q <= StMixCap;
                end

                StMixCap: begin
                    bus.sram_wdata <= mix_res;
                    bus.sram_addr  <= base(trk_dst_q) + ADDR_W'(ptr_q);
                    bus.sram_oe_n  <= 1'b1;
                    bus.sram_we_n  <= 1'b0;
                    state_q        <= StMixWr;
                end

                StMixWr: begin
                    bus.sram_we_n <= 1'b1;
                    if (ptr_inc == mix_n_q) begin
                        len_q[trk_dst_q] <= mix_n_q;
                        state_q          <= StIdle;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                    end else begin
                        ptr_q         <= ptr_inc;
                        bus.sram_addr <= base(trk_a_q) + ADDR_W'(ptr_inc);
                        state_q       <= StMixRdA;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_track_recorder.sv
// Self-checking bench for audio_track_recorder with a small track depth so that the
// track-full path is reachable. Honors AUDIO_REC_MIX_SATURATE_EN for mix expectations.
module tb_audio_track_recorder;

    localparam int unsigned SW = 16;
    localparam int unsigned AW = 18;
    localparam int unsigned NT = 4;
    localparam int unsigned TD = 8;
    localparam int unsigned TW = 2;
    localparam int unsigned MW = $clog2(NT * TD);

`ifdef AUDIO_REC_MIX_SATURATE_EN
    localparam logic [SW-1:0] ExpPos = 16'h7FFF;
    localparam logic [SW-1:0] ExpNeg = 16'h8000;
`else
    localparam logic [SW-1:0] ExpPos = 16'h7000;
    localparam logic [SW-1:0] ExpNeg = 16'hBFFF;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          rst;
    logic          sample_strobe;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [TW-1:0] trk_a;
    logic [TW-1:0] trk_b;
    logic [TW-1:0] trk_dst;
    logic [SW-1:0] audio_in;
    logic [SW-1:0] audio_out;
    logic          audio_valid;
    logic          busy;
    logic          done;
    logic          full;

    audio_track_recorder_if #(.SAMPLE_W(SW), .ADDR_W(AW)) bus ();

    audio_track_recorder #(
        .SAMPLE_W    (SW),
        .ADDR_W      (AW),
        .NUM_TRACKS  (NT),
        .TRACK_DEPTH (TD)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .trk_a         (trk_a),
        .trk_b         (trk_b),
        .trk_dst       (trk_dst),
        .audio_in      (audio_in),
        .audio_out     (audio_out),
        .audio_valid   (audio_valid),
        .busy          (busy),
        .done          (done),
        .full          (full),
        .bus           (bus.master)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // External SRAM device: data returned one cycle after the address.
    logic [SW-1:0] sram [NT*TD];
    always @(posedge CLOCK_50) begin
        if (!bus.sram_we_n && bus.sram_addr < AW'(NT * TD)) begin
            sram[bus.sram_addr[MW-1:0]] <= bus.sram_wdata;
        end
        bus.sram_rdata <= (bus.sram_addr < AW'(NT * TD)) ? sram[bus.sram_addr[MW-1:0]] : 16'hDEAD;
    end

    // Bus monitor: write log, done pulses and bus-rule violations.
    int            wr_cnt    = 0;
    int            done_cnt  = 0;
    int            viol_cnt  = 0;
    bit            prev_we_low = 1'b0;
    logic [AW-1:0] wr_addr_q [$];
    always @(negedge CLOCK_50) begin
        if (!bus.sram_we_n) begin
            wr_addr_q.push_back(bus.sram_addr);
            wr_cnt++;
        end
        if (!bus.sram_we_n && !bus.sram_oe_n) viol_cnt++;
        if (!bus.sram_oe_n && prev_we_low) viol_cnt++;
        if ((!bus.sram_we_n || !bus.sram_oe_n) && bus.sram_addr >= AW'(NT * TD)) viol_cnt++;
        prev_we_low = !bus.sram_we_n;
        if (done === 1'b1) done_cnt++;
    end

    // Reference model state.
    logic [SW-1:0] ref_mem [NT*TD];
    int            ref_len [NT];
    logic [SW-1:0] stim_q  [$];

    int checks = 0;
    int errors = 0;

    function automatic logic [SW-1:0] mix_model(input logic [SW-1:0] a, input logic [SW-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef AUDIO_REC_MIX_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return SW'(s);
`else
        return SW'(s >>> 1);
`endif
    endfunction

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_start(input logic [1:0] m, input int a, input int b, input int d);
        mode    = m;
        trk_a   = TW'(a);
        trk_b   = TW'(b);
        trk_dst = TW'(d);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Records stim_q into track t (stimulus only) and updates the model.
    task automatic record_seq(input int t);
        do_start(2'd0, t, 0, 0);
        for (int i = 0; i < stim_q.size(); i++) begin
            audio_in      = stim_q[i];
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            tick();
            tick();
            ref_mem[t*TD + i] = stim_q[i];
        end
        if (stim_q.size() < TD) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        tick();
        ref_len[t] = stim_q.size();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_wdata, audio_out,
             audio_valid, busy, done, full} !== {1'b1, 1'b1, {AW{1'b0}}, {SW{1'b0}}, {SW{1'b0}},
             4'b0000}) begin
            errors++;
            $display("FAIL reset_values: got we_n=%b oe_n=%b addr=%h wdata=%h out=%h v/b/d/f=%b%b%b%b, want 1 1 0 0 0 0000",
                     bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_wdata, audio_out,
                     audio_valid, busy, done, full);
        end
        for (int t = 0; t < NT; t++) ref_len[t] = 0;
    endtask

    task automatic test_record;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(2'd0, 1, 0, 0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rec_busy: got %b want 1", busy);
        end
        for (int i = 0; i < 5; i++) begin
            audio_in      = SW'(i + 1);
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            checks++;
            if ({bus.sram_we_n, bus.sram_addr, bus.sram_wdata} !== {1'b0, AW'(TD + i), SW'(i + 1)}) begin
                errors++;
                $display("FAIL rec_write%0d: got we_n=%b addr=%0d data=%h want 0 %0d %h",
                         i, bus.sram_we_n, bus.sram_addr, bus.sram_wdata, TD + i, i + 1);
            end
            tick();
            checks++;
            if (bus.sram_we_n !== 1'b1) begin
                errors++;
                $display("FAIL rec_we_one_cycle%0d: got we_n=%b want 1", i, bus.sram_we_n);
            end
            tick();
            ref_mem[TD + i] = SW'(i + 1);
        end
        ref_len[1] = 5;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({done, busy, full} !== 3'b100) begin
            errors++;
            $display("FAIL rec_stop: got done/busy/full=%b%b%b want 100", done, busy, full);
        end
        tick();
        checks++;
        if (done_cnt - d0 !== 1 || wr_cnt - w0 !== 5) begin
            errors++;
            $display("FAIL rec_counts: got done=%0d writes=%0d want 1 5", done_cnt - d0, wr_cnt - w0);
        end
    endtask

    task automatic test_play;
        logic [SW-1:0] exp;
        do_start(2'd1, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            exp           = ref_mem[TD + (k % ref_len[1])];
            sample_strobe = 1'b1;
            tick();
            if (k != 3) sample_strobe = 1'b0;
            checks++;
            if ({bus.sram_oe_n, bus.sram_addr} !== {1'b0, AW'(TD + (k % ref_len[1]))}) begin
                errors++;
                $display("FAIL play_read%0d: got oe_n=%b addr=%0d want 0 %0d",
                         k, bus.sram_oe_n, bus.sram_addr, TD + (k % ref_len[1]));
            end
            tick();
            sample_strobe = 1'b0;
            tick();
            checks++;
            if ({audio_valid, audio_out} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL play_out%0d: got valid=%b out=%h want 1 %h", k, audio_valid, audio_out, exp);
            end
            tick();
            checks++;
            if ({audio_valid, bus.sram_oe_n} !== 2'b01) begin
                errors++;
                $display("FAIL play_idle%0d: got valid=%b oe_n=%b want 0 1", k, audio_valid, bus.sram_oe_n);
            end
        end
        sample_strobe = 1'b1;
        stop          = 1'b1;
        tick();
        sample_strobe = 1'b0;
        stop          = 1'b0;
        checks++;
        if ({bus.sram_oe_n, done, busy} !== 3'b110) begin
            errors++;
            $display("FAIL play_stop_strobe: got oe_n/done/busy=%b%b%b want 110", bus.sram_oe_n, done, busy);
        end
        tick();
    endtask

    // Plays track t for cnt strobes with random gaps and checks looped output.
    task automatic test_play_track(input int t, input int cnt);
        logic [SW-1:0] exp;
        do_start(2'd1, t, 0, 0);
        if (ref_len[t] == 0) begin
            checks++;
            if ({done, busy} !== 2'b10) begin
                errors++;
                $display("FAIL play_empty_t%0d: got done/busy=%b%b want 10", t, done, busy);
            end
            tick();
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            exp           = ref_mem[t*TD + (k % ref_len[t])];
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            tick();
            tick();
            checks++;
            if ({audio_valid, audio_out} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL play_t%0d_%0d: got valid=%b out=%h want 1 %h", t, k, audio_valid, audio_out, exp);
            end
            repeat (1 + $urandom_range(0, 2)) tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL play_t%0d_stop: got done/busy=%b%b want 10", t, done, busy);
        end
        tick();
    endtask

    // Runs a mix and checks duration, destination contents and model update.
    task automatic run_mix(input int a, input int b, input int d);
        int            n;
        int            k;
        logic [SW-1:0] res [TD];
        n = (ref_len[a] < ref_len[b]) ? ref_len[a] : ref_len[b];
        for (int i = 0; i < n; i++) res[i] = mix_model(ref_mem[a*TD + i], ref_mem[b*TD + i]);
        do_start(2'd2, a, b, d);
        k = 1;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1 || k !== 4*n + 1) begin
            errors++;
            $display("FAIL mix_cycles_%0d%0d%0d: got done=%b after %0d cycles want 1 after %0d",
                     a, b, d, done, k, 4*n + 1);
        end
        tick();
        for (int i = 0; i < n; i++) begin
            ref_mem[d*TD + i] = res[i];
            checks++;
            if (sram[d*TD + i] !== res[i]) begin
                errors++;
                $display("FAIL mix_word_%0d%0d%0d_%0d: got %h want %h", a, b, d, i, sram[d*TD + i], res[i]);
            end
        end
        ref_len[d] = n;
    endtask

    task automatic test_mix;
        stim_q = {16'h7000, 16'h8000, SW'($urandom)};
        record_seq(0);
        stim_q = {16'h7000, 16'hFFFF, SW'($urandom), SW'($urandom)};
        record_seq(2);
        run_mix(0, 2, 3);
        checks++;
        if ({sram[3*TD], sram[3*TD + 1]} !== {ExpPos, ExpNeg}) begin
            errors++;
            $display("FAIL mix_corners: got %h %h want %h %h", sram[3*TD], sram[3*TD + 1], ExpPos, ExpNeg);
        end
        test_play_track(3, 5);
        run_mix(2, 0, 2);
        test_play_track(2, 4);
    endtask

    task automatic test_fill;
        int w0;
        int d0;
        w0 = wr_cnt;
        d0 = done_cnt;
        do_start(2'd0, 2, 0, 0);
        for (int i = 0; i < TD + 1; i++) begin
            audio_in      = SW'($urandom);
            sample_strobe = 1'b1;
            tick();
            sample_strobe = 1'b0;
            tick();
            tick();
            if (i < TD) ref_mem[2*TD + i] = audio_in;
        end
        ref_len[2] = TD;
        checks++;
        if ({full, busy} !== 2'b10 || wr_cnt - w0 !== TD || done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL fill: got full/busy=%b%b writes=%0d dones=%0d want 10 %0d 1",
                     full, busy, wr_cnt - w0, done_cnt - d0, TD);
        end
        checks++;
        if (wr_addr_q[w0 + TD - 1] !== AW'(3*TD - 1)) begin
            errors++;
            $display("FAIL fill_last_addr: got %0d want %0d", wr_addr_q[w0 + TD - 1], 3*TD - 1);
        end
        do_start(2'd3, 0, 0, 0);
        checks++;
        if ({busy, full, done} !== 3'b010) begin
            errors++;
            $display("FAIL reserved_mode: got busy/full/done=%b%b%b want 010", busy, full, done);
        end
        tick();
        test_play_track(2, TD + 2);
    endtask

    task automatic test_reset_mid_mix;
        int k;
        do_start(2'd2, 0, 2, 1);
        k = 0;
        while (bus.sram_we_n !== 1'b0 && k < 50) begin
            tick();
            k++;
        end
        checks++;
        if (bus.sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_mix_wait: got we_n=%b after %0d cycles want 0", bus.sram_we_n, k);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_wdata, audio_out,
             audio_valid, busy, done, full} !== {1'b1, 1'b1, {AW{1'b0}}, {SW{1'b0}}, {SW{1'b0}},
             4'b0000}) begin
            errors++;
            $display("FAIL mid_mix_reset: got we_n=%b oe_n=%b addr=%h wdata=%h out=%h v/b/d/f=%b%b%b%b, want 1 1 0 0 0 0000",
                     bus.sram_we_n, bus.sram_oe_n, bus.sram_addr, bus.sram_wdata, audio_out,
                     audio_valid, busy, done, full);
        end
        for (int t = 0; t < NT; t++) ref_len[t] = 0;
        test_play_track(1, 1);
        test_play_track(2, 1);
    endtask

    task automatic test_random;
        int t;
        int n;
        int a;
        int b;
        int d;
        for (int it = 0; it < 6; it++) begin
            t = $urandom_range(0, NT - 1);
            n = $urandom_range(1, TD);
            stim_q = {};
            for (int i = 0; i < n; i++) stim_q.push_back(SW'($urandom));
            record_seq(t);
            test_play_track(t, ref_len[t] + 2);
            a = $urandom_range(0, NT - 1);
            b = $urandom_range(0, NT - 1);
            d = (it % 2 == 0) ? a : $urandom_range(0, NT - 1);
            run_mix(a, b, d);
        end
    endtask

    task automatic test_memory_image;
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < ref_len[t]; i++) begin
                checks++;
                if (sram[t*TD + i] !== ref_mem[t*TD + i]) begin
                    errors++;
                    $display("FAIL image_t%0d_%0d: got %h want %h", t, i, sram[t*TD + i], ref_mem[t*TD + i]);
                end
            end
        end
        checks++;
        if (viol_cnt !== 0) begin
            errors++;
            $display("FAIL bus_rules: got %0d violations want 0", viol_cnt);
        end
    endtask

    initial begin
        rst           = 1'b1;
        sample_strobe = 1'b0;
        start         = 1'b0;
        stop          = 1'b0;
        mode          = 2'd0;
        trk_a         = '0;
        trk_b         = '0;
        trk_dst       = '0;
        audio_in      = '0;
        test_reset();
        test_record();
        test_play();
        test_mix();
        test_fill();
        test_reset_mid_mix();
        test_random();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
